systolic_loader: RTL and testbench
==================================

SYSTOLIC_LOADER -- requirements
Module: systolic_loader

Interface
REQ-001 Parameter ROW, default 4: width of the row operand presented to the systolic array.
REQ-002 Parameter COLUMN, default 12: width of the column operand presented to the systolic array.
REQ-003 Parameter SETTLE, default 3: cycles the array inputs are held stable before arrOut is sampled; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous abort; returns block to LOAD.
REQ-007 inValid  input  1  serial operand bit valid.
REQ-008 inReady  output  1  loader can accept a serial bit.
REQ-009 inBit  input  1  serial operand data.
REQ-010 inRow  output  ROW  row operand driven to systolic array.
REQ-011 inColumn  output  COLUMN  column operand driven to systolic array.
REQ-012 arrOut  input  1  combinational result from systolic array.
REQ-013 resValid  output  1  captured result available.
REQ-014 resReady  input  1  consumer accepts result.
REQ-015 resBit  output  1  captured result.

Function
REQ-016 States SHALL be LOAD, SETTLE, DONE; reset state LOAD.
REQ-017 inReady SHALL be 1 exactly when state is LOAD and clear is 0.
REQ-018 A bit transfers on a rising edge with inValid=1 and inReady=1; no other condition loads operand bits.
REQ-019 Bit order, LSB first: transfer k (k=0..ROW-1) writes inRow[k]; transfer ROW+m (m=0..COLUMN-1) writes inColumn[m].
REQ-020 Bit counter (width $clog2(ROW+COLUMN)) SHALL increment per transfer; on transfer ROW+COLUMN-1 it wraps to 0 and state goes to SETTLE.
REQ-021 On entering SETTLE the settle counter SHALL load SETTLE-1 and decrement each cycle in SETTLE.
REQ-022 In SETTLE with settle counter 0, resBit SHALL capture arrOut and state goes to DONE.
REQ-023 Latency: last bit accepted at edge t -> resBit captured at edge t+SETTLE -> resValid=1 from edge t+SETTLE onward.
REQ-024 inRow/inColumn SHALL be held unchanged throughout SETTLE and DONE.
REQ-025 resValid SHALL be 1 exactly in DONE; resBit stable while resValid=1.
REQ-026 In DONE with resReady=1 the state SHALL go to LOAD on that edge; resValid falls, resBit retains its value.
REQ-027 Operand registers SHALL retain old values in LOAD until overwritten by new transfers.
REQ-028 resReady while not in DONE SHALL be ignored; inValid while not in LOAD SHALL be ignored (no transfer).
REQ-029 clear=1 SHALL override all other inputs on the same edge: state LOAD, both counters 0, resValid 0, inRow/inColumn/resBit 0.
REQ-030 clear during a partial load SHALL discard accepted bits; the next transfer is treated as k=0.

Reset
REQ-031 rst_n=0 SHALL immediately force state LOAD, counters 0, inRow=0, inColumn=0, resBit=0, resValid=0, inReady=1 (once rst_n high and clear low).
REQ-032 Reset assertion mid-load or mid-settle SHALL abandon the operation with no result produced.
REQ-033 Deassertion needs no synchronizer inside the block; synchronization is the integrator's concern.

Structure
REQ-034 Shared package systolic_pkg SHALL hold ROW, COLUMN, derived TOTAL=ROW+COLUMN, counter widths, and the state enumeration.
REQ-035 Block SHALL be flat with no sub-module; the systolic array is instantiated beside it by the integrator, not inside.

Verification
REQ-036 Reset, then stream 16 bits all 1 with inValid held 1 -> inReady low after 16th transfer, inRow=4'hF, inColumn=12'hFFF, resValid=1 exactly 3 cycles after last transfer.
REQ-037 Stream bits 1,0,0,0 then 0,1,0,0,0,0,0,0,0,0,0,1 -> inRow=4'h1, inColumn=12'h802; bench array model drives arrOut=1 -> resBit=1.
REQ-038 inValid toggled randomly during load -> only cycles with inValid=1 and inReady=1 count; inValid=1 during SETTLE/DONE changes nothing.
REQ-039 Hold resReady=0 for 10 cycles in DONE -> resValid and resBit stable; assert resReady -> LOAD next cycle, inReady=1.
REQ-040 clear after 7 transfers -> all outputs 0; new 16-bit stream loads from inRow[0], result correct.
REQ-041 rst_n pulsed low mid-SETTLE (SETTLE=3) -> outputs 0 asynchronously, no resValid pulse, next full stream completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared sizing and state encoding for the systolic operand loader.
package systolic_pkg;

    localparam int ROW    = 4;
    localparam int COLUMN = 12;
    localparam int TOTAL  = ROW + COLUMN;
    localparam int CNT_W  = $clog2(TOTAL);
    localparam int SET_W  = 4;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SETTLE,
        S_DONE
    } state_t;

endpackage

// File: rtl/systolic_loader_if.sv
// Serial operand input and result output handshakes of the loader.
interface systolic_loader_if;

    logic inValid;
    logic inReady;
    logic inBit;
    logic resValid;
    logic resReady;
    logic resBit;

    modport master (
        output inValid, inBit, resReady,
        input  inReady, resValid, resBit
    );

    modport slave (
        input  inValid, inBit, resReady,
        output inReady, resValid, resBit
    );

endinterface

// File: rtl/systolic_loader.sv
// Shifts a serial operand into row/column registers, waits for the
// array to settle, then captures its single-bit result.
module systolic_loader #(
    parameter int ROW    = systolic_pkg::ROW,
    parameter int COLUMN = systolic_pkg::COLUMN,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              arrOut,
    output logic [ROW-1:0]    inRow,
    output logic [COLUMN-1:0] inColumn,
    systolic_loader_if.slave  bus
);

    import systolic_pkg::*;

    localparam int CW = $clog2(ROW + COLUMN);
    localparam int SW = SET_W;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_settle;
    logic [ROW-1:0]    r_row;
    logic [COLUMN-1:0] r_col;
    logic              r_res;
    logic              r_valid;
    logic              w_last;

    assign w_last      = (r_cnt == CW'(ROW + COLUMN - 1));
    assign bus.inReady = (r_state == S_LOAD) && !clear;
    assign bus.resValid = r_valid;
    assign bus.resBit   = r_res;
    assign inRow        = r_row;
    assign inColumn     = r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_settle <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_res    <= 1'b0;
            r_valid  <= 1'b0;
        end else if (clear) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_settle <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_res    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (bus.inValid) begin
                        // Row bits arrive first, LSB first
                        for (int i = 0; i < ROW; i++)
                            if (r_cnt == CW'(i))
                                r_row[i] <= bus.inBit;
                        for (int i = 0; i < COLUMN; i++)
                            if (r_cnt == CW'(ROW + i))
                                r_col[i] <= bus.inBit;
                        if (w_last) begin
                            r_cnt    <= '0;
                            r_settle <= SW'(SETTLE - 1);
                            r_state  <= S_SETTLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_settle == '0) begin
                        r_res   <= arrOut;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.resReady) begin
                        r_valid <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_loader.sv
// Directed bench for systolic_loader with a transaction-level model
// checked every cycle plus literal expectations per scenario.
module tb_systolic_loader;

    localparam int ROW    = 4;
    localparam int COLUMN = 12;
    localparam int SETTLE = 3;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              arrOut;
    logic [ROW-1:0]    inRow;
    logic [COLUMN-1:0] inColumn;

    systolic_loader_if lif ();

    systolic_loader #(
        .ROW    (ROW),
        .COLUMN (COLUMN),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .arrOut   (arrOut),
        .inRow    (inRow),
        .inColumn (inColumn),
        .bus      (lif)
    );

    // Stand-in array: result is the parity of both operands
    assign arrOut = ^{inRow, inColumn};

    int checks = 0;
    int errors = 0;
    bit en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: phase 0 = collecting, 1 = waiting, 2 = result held
    int          m_ph;
    logic [3:0]  m_k;
    logic [15:0] m_ops;
    int          m_wait;
    logic        m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            m_ph   <= 0;
            m_k    <= '0;
            m_ops  <= '0;
            m_wait <= 0;
            m_res  <= 1'b0;
        end else if (m_ph == 0) begin
            if (lif.inValid) begin
                m_ops[m_k] <= lif.inBit;
                m_k        <= m_k + 4'd1;
                if (m_k == 4'd15) begin
                    m_ph   <= 1;
                    m_wait <= SETTLE;
                end
            end
        end else if (m_ph == 1) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_ph  <= 2;
                m_res <= ^m_ops;
            end
        end else if (lif.resReady) begin
            m_ph <= 0;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            #2;
            chk("inReady", 32'(lif.inReady), 32'((m_ph == 0) && !clear));
            chk("resValid", 32'(lif.resValid), 32'(m_ph == 2));
            chk("resBit", 32'(lif.resBit), 32'(m_res));
            chk("inRow", 32'(inRow), 32'(m_ops[3:0]));
            chk("inColumn", 32'(inColumn), 32'(m_ops[15:4]));
        end
    end

    task automatic stream(input logic [15:0] v, input bit gaps,
                          input int cnt);
        int n;
        for (int k = 0; k < cnt; k++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(negedge clk);
                    lif.inValid = 1'b0;
                    lif.inBit   = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            lif.inValid = 1'b1;
            lif.inBit   = v[k];
        end
    endtask

    // Counts falling edges after the last bit was driven until resValid
    task automatic wait_result(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (lif.resValid) break;
        end
        if (!lif.resValid) n = -1;
    endtask

    task automatic ack();
        @(negedge clk);
        lif.resReady = 1'b1;
        @(negedge clk);
        lif.resReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        lif.inValid  = 1'b0;
        lif.inBit    = 1'b0;
        lif.resReady = 1'b0;
        #12;
        chk("rst_inReady", 32'(lif.inReady), 32'd1);
        chk("rst_resValid", 32'(lif.resValid), 32'd0);
        chk("rst_row", 32'(inRow), 32'd0);
        chk("rst_col", 32'(inColumn), 32'd0);
        chk("rst_res", 32'(lif.resBit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // All ones, inValid held high through settle
        stream(16'hFFFF, 1'b0, 16);
        wait_result(n);
        // SETTLE edges after the last transfer edge -> SETTLE+1 negedges
        chk("t1_latency", 32'(n), 32'(SETTLE + 1));
        chk("t1_inReady", 32'(lif.inReady), 32'd0);
        chk("t1_row", 32'(inRow), 32'hF);
        chk("t1_col", 32'(inColumn), 32'hFFF);
        chk("t1_res", 32'(lif.resBit), 32'd0);
        lif.inValid = 1'b0;
        ack();

        // Row 1, column 802, then hold the result for ten cycles
        stream(16'h8021, 1'b0, 16);
        @(negedge clk);
        lif.inValid = 1'b0;
        wait_result(n);
        chk("t2_latency", 32'(n), 32'(SETTLE));
        chk("t2_row", 32'(inRow), 32'h1);
        chk("t2_col", 32'(inColumn), 32'h802);
        chk("t2_res", 32'(lif.resBit), 32'd1);
        repeat (10) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(lif.resValid), 32'd1);
            chk("t4_hold_res", 32'(lif.resBit), 32'd1);
        end
        lif.resReady = 1'b1;
        @(negedge clk);
        lif.resReady = 1'b0;
        chk("t4_inReady", 32'(lif.inReady), 32'd1);
        chk("t4_valid", 32'(lif.resValid), 32'd0);
        chk("t4_res_kept", 32'(lif.resBit), 32'd1);

        // Random inValid gaps, resReady high throughout
        lif.resReady = 1'b1;
        stream(16'h3C97, 1'b1, 16);
        wait_result(n);
        lif.inValid = 1'b0;
        chk("t3_found", 32'(n > 0), 32'd1);
        chk("t3_row", 32'(inRow), 32'h7);
        chk("t3_col", 32'(inColumn), 32'h3C9);
        chk("t3_res", 32'(lif.resBit), 32'd1);
        @(negedge clk);
        lif.resReady = 1'b0;

        // Clear after seven transfers
        stream(16'hFFFF, 1'b0, 7);
        @(negedge clk);
        lif.inValid = 1'b0;
        clear       = 1'b1;
        #1;
        chk("t5_inReady_clr", 32'(lif.inReady), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        chk("t5_row", 32'(inRow), 32'd0);
        chk("t5_col", 32'(inColumn), 32'd0);
        chk("t5_res", 32'(lif.resBit), 32'd0);
        stream(16'hA5C7, 1'b0, 16);
        wait_result(n);
        lif.inValid = 1'b0;
        chk("t5_latency", 32'(n), 32'(SETTLE + 1));
        chk("t5_row2", 32'(inRow), 32'h7);
        chk("t5_col2", 32'(inColumn), 32'hA5C);
        chk("t5_res2", 32'(lif.resBit), 32'd1);
        ack();

        // Reset pulse while settling
        stream(16'h1234, 1'b0, 16);
        @(negedge clk);
        lif.inValid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_row", 32'(inRow), 32'd0);
        chk("t6_col", 32'(inColumn), 32'd0);
        chk("t6_valid", 32'(lif.resValid), 32'd0);
        chk("t6_inReady", 32'(lif.inReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_result", 32'(lif.resValid), 32'd0);
        end
        stream(16'h0F0F, 1'b0, 16);
        wait_result(n);
        lif.inValid = 1'b0;
        chk("t6_latency", 32'(n), 32'(SETTLE + 1));
        chk("t6_row2", 32'(inRow), 32'hF);
        chk("t6_col2", 32'(inColumn), 32'h0F0);
        chk("t6_res2", 32'(lif.resBit), 32'd0);
        ack();
        repeat (2) @(negedge clk);

        en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
